// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: IF/ID bundle, instruction width and the canonical nop.
// Imported by the fetch stage and by the decode stage that consumes if_id_t.
package mips_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc_plus4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc_plus4: 32'h0};

    // Fetch addresses are word aligned; low two bits are always forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, ROM port and IF/ID outputs.
// Exception signals exist only when IF_EXC_REDIRECT_EN is defined.
interface instruction_fetch_stage_if;
    import mips_pkg::*;

    logic               stall;
    logic               redirect_valid;
    logic [31:0]        redirect_target;
    logic [31:0]        instr_addr;
    logic [INSTR_W-1:0] instr_data;
    logic               if_id_valid;
    logic [INSTR_W-1:0] if_id_instr;
    logic [31:0]        if_id_pc_plus4;
`ifdef IF_EXC_REDIRECT_EN
    logic               exc_req;
    logic [31:0]        exc_epc;
    logic               exc_taken;
`endif

    modport master (
        input  stall, redirect_valid, redirect_target, instr_data,
        output instr_addr, if_id_valid, if_id_instr, if_id_pc_plus4
`ifdef IF_EXC_REDIRECT_EN
        , input exc_req, output exc_epc, exc_taken
`endif
    );

    modport slave (
        output stall, redirect_valid, redirect_target, instr_data,
        input  instr_addr, if_id_valid, if_id_instr, if_id_pc_plus4
`ifdef IF_EXC_REDIRECT_EN
        , output exc_req, input exc_epc, exc_taken
`endif
    );

endinterface

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with reset > bubble > hold > load priority.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= IF_ID_BUBBLE;
        end else if (bubble) begin
            q <= IF_ID_BUBBLE;
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC mux and IF/ID register; one-bubble redirects, stalls freeze PC and IF/ID.
// Optional exception redirect to EXC_VECTOR is compiled in with IF_EXC_REDIRECT_EN.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_stage_if.master bus
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        ifid_load;
    logic        ifid_hold;
    logic        ifid_bubble;
    if_id_t      ifid_d;
    if_id_t      ifid_q;

    assign pc_plus4 = pc + 32'd4;

`ifdef IF_EXC_REDIRECT_EN
    logic        exc_fire;
    logic [31:0] exc_epc_q;
    logic        exc_taken_q;
`else
    logic        unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    // Next-PC selection; redirect wins over stall so a squashed branch never waits on a hazard.
    always_comb begin
        pc_next     = pc_plus4;
        ifid_load   = 1'b1;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
`ifdef IF_EXC_REDIRECT_EN
        exc_fire    = 1'b0;
        if (bus.exc_req) begin
            pc_next     = word_align(EXC_VECTOR);
            ifid_load   = 1'b0;
            ifid_bubble = 1'b1;
            exc_fire    = 1'b1;
        end else
`endif
        if (bus.redirect_valid) begin
            pc_next     = word_align(bus.redirect_target);
            ifid_load   = 1'b0;
            ifid_bubble = 1'b1;
        end else if (bus.stall) begin
            pc_next     = pc;
            ifid_load   = 1'b0;
            ifid_hold   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= word_align(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

    assign ifid_d = '{valid: 1'b1, instr: bus.instr_data, pc_plus4: pc_plus4};

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (ifid_load),
        .hold   (ifid_hold),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

`ifdef IF_EXC_REDIRECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_epc_q   <= 32'h0;
            exc_taken_q <= 1'b0;
        end else begin
            exc_taken_q <= exc_fire;
            if (exc_fire) begin
                exc_epc_q <= pc;
            end
        end
    end

    assign bus.exc_epc   = exc_epc_q;
    assign bus.exc_taken = exc_taken_q;
`endif

    assign bus.instr_addr     = pc;
    assign bus.if_id_valid    = ifid_q.valid;
    assign bus.if_id_instr    = ifid_q.instr;
    assign bus.if_id_pc_plus4 = ifid_q.pc_plus4;

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

- PC register and IF/ID pipeline register of the five-stage MIPS pipeline.
- Drives the fetch address into the combinational instruction ROM and captures the returned word with PC+4 for the decode stage.
- Handles hazard stalls and branch/jump redirects; no delay slot, so a redirect squashes the wrong-path word.
- An optional exception redirect can be compiled in.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, exception handler address (used only with IF_EXC_REDIRECT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump/jr resolved in ID.
- redirect_target  in  32  new PC.
- instr_addr  out  32  fetch address to ROM; equals PC register.
- instr_data  in  32  ROM word for instr_addr, same cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  captured instruction.
- if_id_pc_plus4  out  32  PC+4 of captured instruction.
- exc_req  in  1  exception request; present only with IF_EXC_REDIRECT_EN.
- exc_epc  out  32  saved PC; present only with IF_EXC_REDIRECT_EN.
- exc_taken  out  1  one-cycle pulse; present only with IF_EXC_REDIRECT_EN.

## Operation
Each rising edge evaluates one action, in priority order:
- reset
  - PC <= RESET_PC.
  - if_id_valid <= 0, if_id_instr <= 0, if_id_pc_plus4 <= 0.
  - exc_epc <= 0, exc_taken <= 0.
- exception (macro only): PC <= EXC_VECTOR; IF/ID <= bubble; exc_epc <= PC; exc_taken <= 1.
- redirect_valid
  - PC <= {redirect_target[31:2], 2'b00}.
  - IF/ID <= bubble; the wrong-path word fetched this cycle is discarded.
  - Redirect overrides a simultaneous stall.
- stall: PC and all IF/ID fields hold.
- otherwise:
  - PC <= PC + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - if_id_instr <= instr_data; if_id_pc_plus4 <= PC + 4; if_id_valid <= 1.

Other rules:
- Bubble = if_id_valid 0, if_id_instr 32'h0000_0000 (sll $0,$0,0 / nop), if_id_pc_plus4 0.
- PC[1:0] is always 00; instr_addr is never misaligned.
- ROM aliasing above 1 KB is the ROM's concern. This block does not range-check.
- exc_taken deasserts on the next edge unless another exception is taken.

## Timing
- instr_addr is a direct register output; ROM lookup is combinational in the same cycle.
- Fetch latency: word at PC N appears on if_id_instr one edge after N is on instr_addr.
- Redirect penalty: exactly one bubble. The target word is on if_id_instr two edges after redirect_valid is sampled.
- Stall held k cycles: IF/ID and PC frozen k cycles; no word lost or duplicated.
- Reset mid-operation discards any pending redirect or stall. First valid IF/ID contents appear one edge after reset drops.
- Inputs are sampled only at the rising edge. No combinational path from any input to any output.

## Configuration
- IF_EXC_REDIRECT_EN defined:
  - exc_req, exc_epc and exc_taken ports exist.
  - Exception has priority over redirect and stall.
- Not defined:
  - The three ports are absent and EXC_VECTOR is unused.
  - Priority is reset > redirect > stall > sequential.

## Structure
- Shared package mips_pkg holds:
  - NOP_INSTR (32'h0000_0000) and INSTR_W (32).
  - The if_id_t bundle: valid, instr, pc_plus4.
  - The decode stage imports the same if_id_t.
- One natural sub-module, if_id_reg, holds the IF/ID register.
  - Controls: load, hold, bubble, reset.
  - The PC and next-PC mux stay in the top module.

## Test plan
- Reset then free-run 3 cycles → instr_addr 0,4,8; if_id_pc_plus4 4,8,12; if_id_valid 0 then 1.
- redirect_valid=1, target 32'h0000_000C while PC=8 → next PC 0xC and IF/ID bubble (valid 0, instr 0); word at 0xC appears the following edge.
- stall high 3 cycles at PC=0x10 → instr_addr and IF/ID unchanged for 3 edges; resumes with PC 0x14.
- stall and redirect (target 32'h0000_0042) together → PC 0x40, bubble inserted; stall ignored.
- PC=32'hFFFF_FFFC, no stall → next PC 0, if_id_pc_plus4 0.
- With IF_EXC_REDIRECT_EN: exc_req and redirect together at PC 0x24 → PC 0x80, exc_epc 0x24, exc_taken high one cycle, IF/ID bubble.
